// File: rtl/ray_march_stepper_pkg.sv
// Shared ray-marcher types and Q16.16 arithmetic helpers.
package ray_march_stepper_pkg;

  typedef logic signed [31:0] fp;

  typedef struct packed {
    fp x;
    fp y;
    fp z;
  } vec3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } march_state_e;

  localparam fp FP_ONE     = 32'sh0001_0000;
  localparam fp FP_HALF    = 32'sh0000_8000;
  localparam fp FP_QUARTER = 32'sh0000_4000;
  localparam fp FP_MAX     = 32'sh7FFF_FFFF;
  localparam fp FP_MIN     = 32'sh8000_0000;

  function automatic vec3 make_vec3(input fp x, input fp y, input fp z);
    vec3 v;
    v.x = x;
    v.y = y;
    v.z = z;
    return v;
  endfunction

  // Saturating add: clamps to the most positive / most negative fp value.
  function automatic fp fp_add(input fp a, input fp b);
    logic [32:0] sum;
    fp           res;
    sum = {a[31], a} + {b[31], b};
    if (sum[32] != sum[31]) begin
      if (sum[32]) begin
        res = FP_MIN;
      end else begin
        res = FP_MAX;
      end
    end else begin
      res = fp'(sum[31:0]);
    end
    return res;
  endfunction

  // Q16.16 multiply: full 64-bit signed product, arithmetic shift by 16, keep low 32 bits.
  function automatic fp fp_mul(input fp a, input fp b);
    logic signed [63:0] prod;
    logic signed [63:0] shifted;
    prod    = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    shifted = prod >>> 16;
    return fp'(shifted[31:0]);
  endfunction

  function automatic vec3 vec3_add(input vec3 a, input vec3 b);
    return make_vec3(fp_add(a.x, b.x), fp_add(a.y, b.y), fp_add(a.z, b.z));
  endfunction

  function automatic vec3 vec3_scale(input vec3 v, input fp s);
    return make_vec3(fp_mul(v.x, s), fp_mul(v.y, s), fp_mul(v.z, s));
  endfunction

endpackage

// File: rtl/ray_march_stepper_point_eval.sv
// Combinational sample-point evaluator: origin + dir * t, per lane.
module ray_point_eval
  import ray_march_stepper_pkg::*;
(
  input  vec3 origin,
  input  vec3 dir,
  input  fp   t,
  output vec3 point
);

  assign point = vec3_add(origin, vec3_scale(dir, t));

endmodule

// File: rtl/ray_march_stepper.sv
// Sphere-tracing controller: issues SDF sample points along one ray at a time,
// advances t by the returned distance, and reports hit / miss / budget exhaustion.
module ray_march_stepper
  import ray_march_stepper_pkg::*;
#(
  parameter int unsigned MAX_STEPS = 64,
  parameter fp           HIT_EPS   = 32'sh0000_0041,
  parameter fp           MAX_DIST  = 32'sh0014_0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  vec3        origin,
  input  vec3        dir,
  output logic       ready,
  output logic       sdf_valid_out,
  output vec3        sdf_point,
  input  logic       sdf_valid_in,
  input  fp          sdf_distance,
  output logic       done,
  output logic       hit,
  output fp          hit_t,
  output vec3        hit_point,
  output logic [7:0] step_count
);

  localparam logic [7:0] MAX_STEPS_C = MAX_STEPS[7:0];

  march_state_e state_q, state_d;
  vec3          origin_q, origin_d;
  vec3          dir_q, dir_d;
  fp            t_q, t_d;
  logic [7:0]   steps_q, steps_d;
  logic         ready_q, ready_d;
  logic         sdf_valid_out_q, sdf_valid_out_d;
  vec3          sdf_point_q, sdf_point_d;
  logic         done_q, done_d;
  logic         hit_q, hit_d;
  fp            hit_t_q, hit_t_d;
  vec3          hit_point_q, hit_point_d;
  logic [7:0]   step_count_q, step_count_d;

  fp            t_next_s;
  logic [7:0]   steps_inc_s;
  vec3          next_point_s;

  assign t_next_s    = fp_add(t_q, sdf_distance);
  assign steps_inc_s = steps_q + 8'd1;

  ray_point_eval u_point_eval (
    .origin (origin_q),
    .dir    (dir_q),
    .t      (t_next_s),
    .point  (next_point_s)
  );

  // Next-state and next-output computation for the marching FSM.
  always_comb begin
    state_d         = state_q;
    origin_d        = origin_q;
    dir_d           = dir_q;
    t_d             = t_q;
    steps_d         = steps_q;
    ready_d         = ready_q;
    sdf_valid_out_d = 1'b0;
    sdf_point_d     = sdf_point_q;
    done_d          = 1'b0;
    hit_d           = hit_q;
    hit_t_d         = hit_t_q;
    hit_point_d     = hit_point_q;
    step_count_d    = step_count_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          origin_d        = origin;
          dir_d           = dir;
          t_d             = 32'sh0000_0000;
          steps_d         = 8'd0;
          sdf_point_d     = origin;
          ready_d         = 1'b0;
          sdf_valid_out_d = 1'b1;
          state_d         = ST_ISSUE;
        end else begin
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (sdf_valid_in) begin
          steps_d = steps_inc_s;
          if (sdf_distance < HIT_EPS) begin
            // Close enough (or inside the surface): t stays where it was.
            hit_d        = 1'b1;
            hit_t_d      = t_q;
            hit_point_d  = sdf_point_q;
            step_count_d = steps_inc_s;
            done_d       = 1'b1;
            state_d      = ST_DONE;
          end else if ((t_next_s > MAX_DIST) || (steps_inc_s == MAX_STEPS_C)) begin
            // Escaped past the far limit or out of budget: report a miss at the advanced t.
            t_d          = t_next_s;
            hit_d        = 1'b0;
            hit_t_d      = t_next_s;
            hit_point_d  = sdf_point_q;
            step_count_d = steps_inc_s;
            done_d       = 1'b1;
            state_d      = ST_DONE;
          end else begin
            t_d             = t_next_s;
            sdf_point_d     = next_point_s;
            sdf_valid_out_d = 1'b1;
            state_d         = ST_ISSUE;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_DONE: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered-output flops; reset aborts any ray in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      origin_q        <= '0;
      dir_q           <= '0;
      t_q             <= 32'sh0000_0000;
      steps_q         <= 8'd0;
      ready_q         <= 1'b1;
      sdf_valid_out_q <= 1'b0;
      sdf_point_q     <= '0;
      done_q          <= 1'b0;
      hit_q           <= 1'b0;
      hit_t_q         <= 32'sh0000_0000;
      hit_point_q     <= '0;
      step_count_q    <= 8'd0;
    end else begin
      state_q         <= state_d;
      origin_q        <= origin_d;
      dir_q           <= dir_d;
      t_q             <= t_d;
      steps_q         <= steps_d;
      ready_q         <= ready_d;
      sdf_valid_out_q <= sdf_valid_out_d;
      sdf_point_q     <= sdf_point_d;
      done_q          <= done_d;
      hit_q           <= hit_d;
      hit_t_q         <= hit_t_d;
      hit_point_q     <= hit_point_d;
      step_count_q    <= step_count_d;
    end
  end

  assign ready         = ready_q;
  assign sdf_valid_out = sdf_valid_out_q;
  assign sdf_point     = sdf_point_q;
  assign done          = done_q;
  assign hit           = hit_q;
  assign hit_t         = hit_t_q;
  assign hit_point     = hit_point_q;
  assign step_count    = step_count_q;

endmodule

// File: tb/tb_ray_march_stepper.sv
// Directed self-checking bench for ray_march_stepper with a behavioural SDF responder.
module tb_ray_march_stepper;
  import ray_march_stepper_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  vec3        origin;
  vec3        dir;
  logic       ready;
  logic       sdf_valid_out;
  vec3        sdf_point;
  logic       sdf_valid_in;
  fp          sdf_distance;
  logic       done;
  logic       hit;
  fp          hit_t;
  vec3        hit_point;
  logic [7:0] step_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ray_march_stepper dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .origin        (origin),
    .dir           (dir),
    .ready         (ready),
    .sdf_valid_out (sdf_valid_out),
    .sdf_point     (sdf_point),
    .sdf_valid_in  (sdf_valid_in),
    .sdf_distance  (sdf_distance),
    .done          (done),
    .hit           (hit),
    .hit_t         (hit_t),
    .hit_point     (hit_point),
    .step_count    (step_count)
  );

  task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Distance sources: 0 = unit sphere at the origin (rays stay on the z axis),
  // 1 = constant 1.0, 2 = constant 0.01, 3 = constant -0.5, 4 = 1.0 then max fp.
  function automatic fp model_dist(input int mode, input int idx, input vec3 p);
    fp az;
    case (mode)
      0: begin
        az = (p.z < 0) ? -p.z : p.z;
        return az - FP_ONE;
      end
      1: return 32'sh0001_0000;
      2: return 32'sh0000_028F;
      3: return -32'sh0000_8000;
      4: return (idx == 0) ? 32'sh0001_0000 : 32'sh7FFF_FFFF;
      default: return 32'sh0000_0000;
    endcase
  endfunction

  task automatic run_ray(input vec3 o, input vec3 dv, input int mode, input bit rand_lat,
                         input bit poke, output logic r_hit, output fp r_t, output vec3 r_pt,
                         output logic [7:0] r_steps, output int n_done, output bit timing_ok);
    int  n_req;
    int  lat;
    int  guard;
    bit  finished;
    vec3 p;
    fp   d;
    n_req = 0; n_done = 0; timing_ok = 1'b1; finished = 1'b0; guard = 0;
    r_hit = 1'b0; r_t = 32'sh0; r_pt = '0; r_steps = 8'd0;
    @(negedge clk);
    origin = o; dir = dv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!finished) begin
      if (done) begin
        n_done++;
        r_hit = hit; r_t = hit_t; r_pt = hit_point; r_steps = step_count;
        if (ready) timing_ok = 1'b0;
        finished = 1'b1;
      end else if (sdf_valid_out) begin
        p   = sdf_point;
        d   = model_dist(mode, n_req, p);
        lat = rand_lat ? int'($urandom_range(1, 7)) : 1;
        if (poke && n_req == 0) lat = 3;
        for (int i = 0; i < lat; i++) begin
          @(negedge clk);
          if (sdf_point !== p || sdf_valid_out || ready || done) timing_ok = 1'b0;
          if (poke && n_req == 0 && i == 0) begin
            start  = 1'b1;
            origin = make_vec3(FP_ONE, FP_ONE, FP_ONE);
          end else begin
            start  = 1'b0;
            origin = o;
          end
        end
        sdf_valid_in = 1'b1; sdf_distance = d;
        @(negedge clk);
        sdf_valid_in = 1'b0;
        n_req++;
        if (!done && !sdf_valid_out) timing_ok = 1'b0;
      end else begin
        // Every request/response must produce a reaction in the very next cycle.
        timing_ok = 1'b0;
        @(negedge clk);
        guard++;
        if (guard > 40) finished = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0 && !ready) timing_ok = 1'b0;
      if (done) n_done++;
    end
  endtask

  task automatic expect_ray(input string name, input vec3 o, input vec3 dv, input int mode,
                            input bit rand_lat, input bit poke, input logic e_hit, input fp e_t,
                            input vec3 e_pt, input logic [7:0] e_steps);
    logic       r_hit;
    fp          r_t;
    vec3        r_pt;
    logic [7:0] r_steps;
    int         n_done;
    bit         timing_ok;
    run_ray(o, dv, mode, rand_lat, poke, r_hit, r_t, r_pt, r_steps, n_done, timing_ok);
    check_eq({name, ".hit"}, r_hit, e_hit);
    check_eq({name, ".hit_t"}, r_t, e_t);
    check_eq({name, ".hit_point"}, r_pt, e_pt);
    check_eq({name, ".step_count"}, r_steps, e_steps);
    check_eq({name, ".done_count"}, n_done, 1);
    check_eq({name, ".timing"}, timing_ok, 1'b1);
  endtask

  task automatic check_reset_outputs(input string name);
    check_eq({name, ".ready"}, ready, 1'b1);
    check_eq({name, ".sdf_valid_out"}, sdf_valid_out, 1'b0);
    check_eq({name, ".done"}, done, 1'b0);
    check_eq({name, ".hit"}, hit, 1'b0);
    check_eq({name, ".sdf_point"}, sdf_point, 96'h0);
    check_eq({name, ".hit_t"}, hit_t, 96'h0);
    check_eq({name, ".hit_point"}, hit_point, 96'h0);
    check_eq({name, ".step_count"}, step_count, 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec3 zero_v, z_dir, x_dir, o_sph, o_mix, o_x1;
    int  late_done;
    int  late_req;
    zero_v = make_vec3(32'sh0, 32'sh0, 32'sh0);
    z_dir  = make_vec3(32'sh0, 32'sh0, FP_ONE);
    x_dir  = make_vec3(FP_ONE, 32'sh0, 32'sh0);
    o_sph  = make_vec3(32'sh0, 32'sh0, -32'sh0003_0000);
    o_mix  = make_vec3(32'sh0000_2000, 32'sh0000_3000, -FP_ONE);
    o_x1   = make_vec3(FP_ONE, 32'sh0, 32'sh0);

    rst_n = 1'b0; start = 1'b0; origin = '0; dir = '0;
    sdf_valid_in = 1'b0; sdf_distance = 32'sh0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Stray response while idle must not move anything.
    sdf_valid_in = 1'b1; sdf_distance = FP_ONE;
    @(negedge clk);
    sdf_valid_in = 1'b0;
    @(negedge clk);
    check_reset_outputs("stray_idle");

    expect_ray("sphere", o_sph, z_dir, 0, 1'b0, 1'b0, 1'b1, 32'sh0002_0000,
               make_vec3(32'sh0, 32'sh0, -FP_ONE), 8'd2);
    expect_ray("far", zero_v, x_dir, 1, 1'b0, 1'b0, 1'b0, 32'sh0015_0000,
               make_vec3(32'sh0014_0000, 32'sh0, 32'sh0), 8'd21);
    expect_ray("budget", zero_v, z_dir, 2, 1'b0, 1'b0, 1'b0, 32'sh0000_A3C0,
               make_vec3(32'sh0, 32'sh0, 32'sh0000_A131), 8'd64);
    expect_ray("neg_first", o_mix, z_dir, 3, 1'b0, 1'b0, 1'b1, 32'sh0, o_mix, 8'd1);
    expect_ray("saturate", o_x1, z_dir, 4, 1'b0, 1'b0, 1'b0, 32'sh7FFF_FFFF,
               make_vec3(FP_ONE, 32'sh0, FP_ONE), 8'd2);
    expect_ray("start_in_wait", o_sph, z_dir, 0, 1'b0, 1'b1, 1'b1, 32'sh0002_0000,
               make_vec3(32'sh0, 32'sh0, -FP_ONE), 8'd2);
    expect_ray("sphere_varlat", o_sph, z_dir, 0, 1'b1, 1'b0, 1'b1, 32'sh0002_0000,
               make_vec3(32'sh0, 32'sh0, -FP_ONE), 8'd2);
    expect_ray("far_varlat", zero_v, x_dir, 1, 1'b1, 1'b0, 1'b0, 32'sh0015_0000,
               make_vec3(32'sh0014_0000, 32'sh0, 32'sh0), 8'd21);

    // Reset while waiting on the SDF, then deliver the late response.
    @(negedge clk);
    origin = o_sph; dir = z_dir; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("abort.request_issued", sdf_valid_out, 1'b1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("abort.in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    sdf_valid_in = 1'b1; sdf_distance = 32'sh0002_0000;
    @(negedge clk);
    sdf_valid_in = 1'b0;
    late_done = 0; late_req = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) late_done++;
      if (sdf_valid_out) late_req++;
      @(negedge clk);
    end
    check_eq("abort.late_done", late_done, 0);
    check_eq("abort.late_request", late_req, 0);
    check_reset_outputs("abort.after_late");

    expect_ray("after_abort", o_mix, z_dir, 3, 1'b0, 1'b0, 1'b1, 32'sh0, o_mix, 8'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
